sprite_line_engine: RTL

Parametrised sprite pixel engine for the PPU: holds up to NUM_SLOTS sprites for one scanline, double-buffered so the next line's sprites load while the current line renders. Each dot, it emits the highest-priority opaque sprite pixel with its priority bit and a sprite-0 opaque flag. The background/sprite pixel mux in the renderer consumes these outputs. It generalises the fixed 8-sprite shifter bank with configurable slot count, horizontal flip on load, an overflow flag, and optional left-column clipping.

---
 rtl/ppu_pkg.sv | 43 ++++
 rtl/sprite_slot.sv | 49 ++++
 rtl/sprite_line_engine.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU sprite pipeline.
package ppu_pkg;

    // OAM attribute byte as seen on the load port.
    typedef struct packed {
        logic       flip_v;
        logic       flip_h;
        logic       pri;
        logic [2:0] rsvd;
        logic [1:0] pal;
    } sp_attr_t;

    // One sprite slot: pattern planes, X position / counter preload, palette, priority.
    typedef struct packed {
        logic [7:0] pat0;
        logic [7:0] pat1;
        logic [7:0] x;
        logic [1:0] pal;
        logic       pri;
    } sp_slot_t;

    localparam int SP_ATTR_PRI   = 5;
    localparam int SP_ATTR_FLIPH = 6;

    // An empty slot: no pattern bits, parked off-screen, behind the background.
    localparam sp_slot_t SP_TRANSPARENT = '{
        pat0: 8'h00,
        pat1: 8'h00,
        x:    8'hFF,
        pal:  2'b00,
        pri:  1'b1
    };

    // Mirror a pattern byte so the leftmost pixel becomes the rightmost.
    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_slot.sv
// One active sprite slot: X down-counter, two pattern shifters and pixel output.
module sprite_slot
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  sp_slot_t   i_slot,
    input  logic       i_px_en,
    output logic [3:0] o_px,
    output logic       o_pri
);

    logic [7:0] r_cnt;
    logic [7:0] r_pat0;
    logic [7:0] r_pat1;
    logic [1:0] r_pal;
    logic       r_pri;

    // Load on commit; otherwise count down to the sprite, then shift its pixels out.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values; blocking here would create order-dependent races.
        if (rst) begin
            r_cnt  <= 8'hFF;
            r_pat0 <= 8'h00;
            r_pat1 <= 8'h00;
            r_pal  <= 2'b00;
            r_pri  <= 1'b1;
        end else if (i_load) begin
            r_cnt  <= i_slot.x;
            r_pat0 <= i_slot.pat0;
            r_pat1 <= i_slot.pat1;
            r_pal  <= i_slot.pal;
            r_pri  <= i_slot.pri;
        end else if (i_px_en) begin
            if (r_cnt != 8'h00) begin
                r_cnt <= r_cnt - 8'h01;
            end else begin
                r_pat0 <= {r_pat0[6:0], 1'b0};
                r_pat1 <= {r_pat1[6:0], 1'b0};
            end
        end
    end

    assign o_px  = (r_cnt == 8'h00) ? {r_pal, r_pat1[7], r_pat0[7]} : 4'h0;
    assign o_pri = r_pri;

endmodule

// File: rtl/sprite_line_engine.sv
// Double-buffered per-scanline sprite engine: staging bank + load pointer,
// NUM_SLOTS active sprite_slot instances and a lowest-index-wins pixel mux.
// Optional feature macro: SP_LEFT_CLIP_EN (blank sprites in dots 0..7 when show_left=0).
module sprite_line_engine
    import ppu_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int IDX_W     = $clog2(NUM_SLOTS + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld_start,
    input  logic       ld_valid,
    input  logic [7:0] ld_attr,
    input  logic [7:0] ld_x,
    input  logic [7:0] ld_pat0,
    input  logic [7:0] ld_pat1,
    input  logic       ld_inscan,
    input  logic       ld_sp0,
    input  logic       commit,
    input  logic       px_en,
    input  logic [7:0] px_x,
    input  logic       show_left,
    output logic [3:0] sp_px,
    output logic       sp_pri,
    output logic       sp0_opaque,
    output logic       ld_overflow
);

    sp_slot_t   r_stage [NUM_SLOTS];
    logic [IDX_W-1:0] r_ptr;
    logic       r_ovf;
    logic       r_sp0_stage;
    logic       r_sp0_active;

    sp_attr_t   w_attr;
    sp_slot_t   w_entry;
    logic [7:0] w_pat0;
    logic [7:0] w_pat1;
    logic [IDX_W-1:0] w_ptr_cur;
    logic       w_full;
    logic       w_write;
    logic       w_clip;
    logic [3:0] w_slot_px  [NUM_SLOTS];
    logic       w_slot_pri [NUM_SLOTS];

    // A same-cycle ld_start clears first, so the write then lands in slot 0.
    assign w_attr    = sp_attr_t'(ld_attr);
    assign w_ptr_cur = ld_start ? '0 : r_ptr;
    assign w_full    = (w_ptr_cur == IDX_W'(NUM_SLOTS));
    assign w_write   = ld_valid && !w_full;

    assign w_pat0  = !ld_inscan ? 8'h00 : (ld_attr[SP_ATTR_FLIPH] ? bit_rev8(ld_pat0) : ld_pat0);
    assign w_pat1  = !ld_inscan ? 8'h00 : (ld_attr[SP_ATTR_FLIPH] ? bit_rev8(ld_pat1) : ld_pat1);
    assign w_entry = '{pat0: w_pat0, pat1: w_pat1, x: ld_x, pal: w_attr.pal,
                       pri: ld_attr[SP_ATTR_PRI]};

    // Staging bank, load pointer, overflow flag and sp0 staging flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the staging bank is a handful of flops with a defined empty state,
            // so it is reset like any other register rather than treated as RAM.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_stage[i] <= SP_TRANSPARENT;
            end
            r_ptr       <= '0;
            r_ovf       <= 1'b0;
            r_sp0_stage <= 1'b0;
        end else begin
            if (ld_start) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    r_stage[i] <= SP_TRANSPARENT;
                end
                r_sp0_stage <= 1'b0;
            end
            if (w_write) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (w_ptr_cur == IDX_W'(i)) begin
                        r_stage[i] <= w_entry;
                    end
                end
                if (w_ptr_cur == '0) begin
                    r_sp0_stage <= ld_sp0;
                end
            end
            r_ptr <= w_write ? (w_ptr_cur + IDX_W'(1)) : w_ptr_cur;
            r_ovf <= (ld_start ? 1'b0 : r_ovf) | (ld_valid && w_full);
        end
    end

    // Sprite-0 tag follows the staging bank into the active bank on commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp0_active <= 1'b0;
        end else if (commit) begin
            r_sp0_active <= r_sp0_stage;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        sprite_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_load  (commit),
            .i_slot  (r_stage[g]),
            .i_px_en (px_en),
            .o_px    (w_slot_px[g]),
            .o_pri   (w_slot_pri[g])
        );
    end

`ifdef SP_LEFT_CLIP_EN
    logic [1:0] w_unused;
    assign w_clip = !show_left && (px_x < 8'd8);
`else
    logic [10:0] w_unused;
    assign w_clip = 1'b0;
    assign w_unused[10:2] = {show_left, px_x};
`endif
    assign w_unused[1:0] = {w_attr.flip_v, ^w_attr.rsvd};

    // Lowest-index opaque slot wins; transparent defaults when idle or clipped.
    always_comb begin
        // NOTE: every output gets a default before any condition so no path
        // leaves a value unassigned, which would infer a latch.
        sp_px      = 4'h0;
        sp_pri     = 1'b1;
        sp0_opaque = 1'b0;
        if (px_en && !w_clip) begin
            for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
                if (w_slot_px[i][1:0] != 2'b00) begin
                    sp_px  = w_slot_px[i];
                    sp_pri = w_slot_pri[i];
                end
            end
            sp0_opaque = r_sp0_active && (w_slot_px[0][1:0] != 2'b00);
        end
    end

    assign ld_overflow = r_ovf;

endmodule
